// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared decode definitions for the instruction-decode stage:
//   - RV32I major opcode constants handled by the decoder
//   - alu_op_e   : 4-bit ALU operation handed to execute
//   - imm_type_e : immediate format selector for id_imm_gen
//   - id_state_e : decode-stage handshake FSM states
//   - alu_from_funct3 : funct3 (+ alternate bit) to ALU op mapping
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4
    } imm_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } id_state_e;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// ----------------------------------------------------------------------------
// id_imm_gen
// Purely combinational immediate generator. Assembles the I/S/B/U immediate
// from the instruction word and sign-extends it to XLEN.
// Ports:
//   instr    (in, [31:7]) instruction bits above the opcode
//   imm_type (in, 3)      imm_type_e selector; IMM_NONE yields zero
//   imm      (out, XLEN)  sign-extended immediate
// ----------------------------------------------------------------------------
module id_imm_gen
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // signed size cast sign-extends when XLEN > 32
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
// Instruction-decode stage with valid/ready handshakes on both sides.
// Register addresses go straight from if_instr to the synchronous regfile so
// the read is issued on the accept edge; decoded fields are registered on
// accept and operands arrive one cycle later (READ). If execute stalls, the
// operands are captured locally (HOLD) so all ex_* outputs stay stable.
//
// Optional build macro: ID_BYPASS_EN -- forwards writeback-port writes into
// the operands (live write > accept-edge capture > regfile/hold capture).
// Without it the wb_* ports are present but ignored.
//
// Ports:
//   clk, rstn                        clock, async active-low reset
//   if_valid/if_ready/if_instr/if_pc fetch handshake and payload
//   rf_radd1/2, rf_rdata1/2          regfile read addresses / data (+1 cycle)
//   wb_we/wb_wadd/wb_wdata           writeback snoop
//   ex_valid/ex_ready                execute handshake
//   ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_op, ex_wreg, ex_illegal
// ----------------------------------------------------------------------------
module id_stage
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [31:0]        if_instr,
    input  logic [XLEN-1:0]    if_pc,
    output logic [RADDR_W-1:0] rf_radd1,
    output logic [RADDR_W-1:0] rf_radd2,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_wadd,
    input  logic [XLEN-1:0]    wb_wdata,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_val,
    output logic [XLEN-1:0]    ex_rs2_val,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [3:0]         ex_op,
    output logic               ex_wreg,
    output logic               ex_illegal
);

    id_state_e state, state_nxt;

    logic accept;
    logic fire;

    // ---------------- decode (combinational, from if_instr) ----------------
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [RADDR_W-1:0] rd_addr;
    alu_op_e            dec_op;
    logic [2:0]         dec_imm_type;
    logic               dec_wreg;
    logic               dec_ill;
    logic [XLEN-1:0]    dec_imm;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign rs1_addr = RADDR_W'(if_instr[19:15]);
    assign rs2_addr = RADDR_W'(if_instr[24:20]);
    assign rd_addr  = RADDR_W'(if_instr[11:7]);

    assign rf_radd1 = rs1_addr;
    assign rf_radd2 = rs2_addr;

    always_comb begin
        dec_op       = ALU_ADD;
        dec_imm_type = IMM_NONE;
        dec_wreg     = 1'b0;
        dec_ill      = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_op   = alu_from_funct3(funct3, if_instr[30]);
                dec_wreg = 1'b1;
            end
            OPC_OP_IMM: begin
                // bit 30 is immediate data for addi; it only means SRA for shifts
                dec_op       = alu_from_funct3(funct3, if_instr[30] && (funct3 == 3'b101));
                dec_imm_type = IMM_I;
                dec_wreg     = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm_type = IMM_I;
                dec_wreg     = 1'b1;
            end
            OPC_STORE: begin
                dec_imm_type = IMM_S;
            end
            OPC_LUI: begin
                dec_op       = ALU_LUI;
                dec_imm_type = IMM_U;
                dec_wreg     = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm_type = IMM_B;
                if (funct3[2])
                    dec_op = funct3[1] ? ALU_SLTU : ALU_SLT;
                else
                    dec_op = ALU_SUB;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        if (rd_addr == '0)
            dec_wreg = 1'b0;
    end

    id_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr    (if_instr[31:7]),
        .imm_type (dec_imm_type),
        .imm      (dec_imm)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = READ;
            end
            READ, HOLD: begin
                if (ex_ready)
                    state_nxt = accept ? READ : IDLE;
                else
                    state_nxt = HOLD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if_ready = 1'b0;
        ex_valid = 1'b0;
        case (state)
            IDLE: if_ready = 1'b1;
            READ, HOLD: begin
                if_ready = ex_ready;
                ex_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = if_valid && if_ready;
    assign fire   = ex_valid && ex_ready;

    // ---------------- stage p1: fields registered on accept ----------------
    logic [XLEN-1:0]    pc_p1;
    logic [XLEN-1:0]    imm_p1;
    logic [RADDR_W-1:0] rd_p1;
    alu_op_e            op_p1;
    logic               wreg_p1;
    logic               ill_p1;
    logic               rs1_zero_p1;
    logic               rs2_zero_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_p1       <= '0;
            imm_p1      <= '0;
            rd_p1       <= '0;
            op_p1       <= ALU_ADD;
            wreg_p1     <= 1'b0;
            ill_p1      <= 1'b0;
            rs1_zero_p1 <= 1'b0;
            rs2_zero_p1 <= 1'b0;
        end else if (accept) begin
            pc_p1       <= if_pc;
            imm_p1      <= dec_imm;
            rd_p1       <= rd_addr;
            op_p1       <= dec_op;
            wreg_p1     <= dec_wreg;
            ill_p1      <= dec_ill;
            rs1_zero_p1 <= (rs1_addr == '0);
            rs2_zero_p1 <= (rs2_addr == '0);
        end
    end

    // ---------------- operand selection ----------------
    logic [XLEN-1:0] hold1_p2;
    logic [XLEN-1:0] hold2_p2;
    logic [XLEN-1:0] opnd1;
    logic [XLEN-1:0] opnd2;

`ifdef ID_BYPASS_EN
    logic [RADDR_W-1:0] rs1_p1;
    logic [RADDR_W-1:0] rs2_p1;
    logic               bp1_vld_p1;
    logic               bp2_vld_p1;
    logic [XLEN-1:0]    bp1_dat_p1;
    logic [XLEN-1:0]    bp2_dat_p1;
    logic               live1;
    logic               live2;

    // A write landing on the accept edge is missed by the regfile read,
    // so it is remembered here for the READ cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            bp1_vld_p1 <= 1'b0;
            bp2_vld_p1 <= 1'b0;
            bp1_dat_p1 <= '0;
            bp2_dat_p1 <= '0;
        end else if (accept) begin
            rs1_p1     <= rs1_addr;
            rs2_p1     <= rs2_addr;
            bp1_vld_p1 <= wb_we && (rs1_addr != '0) && (wb_wadd == rs1_addr);
            bp2_vld_p1 <= wb_we && (rs2_addr != '0) && (wb_wadd == rs2_addr);
            bp1_dat_p1 <= wb_wdata;
            bp2_dat_p1 <= wb_wdata;
        end
    end

    assign live1 = wb_we && !rs1_zero_p1 && (wb_wadd == rs1_p1);
    assign live2 = wb_we && !rs2_zero_p1 && (wb_wadd == rs2_p1);
`else
    logic wb_unused;
    assign wb_unused = ^{wb_we, wb_wadd, wb_wdata};
`endif

    always_comb begin
        opnd1 = rs1_zero_p1 ? '0 : rf_rdata1;
        opnd2 = rs2_zero_p1 ? '0 : rf_rdata2;
        if (state == HOLD) begin
            opnd1 = hold1_p2;
            opnd2 = hold2_p2;
        end
`ifdef ID_BYPASS_EN
        if (state == READ && bp1_vld_p1) opnd1 = bp1_dat_p1;
        if (state == READ && bp2_vld_p1) opnd2 = bp2_dat_p1;
        if (live1) opnd1 = wb_wdata;
        if (live2) opnd2 = wb_wdata;
`endif
        if (state == IDLE) begin
            opnd1 = '0;
            opnd2 = '0;
        end
    end

    // ---------------- stage p2: operand capture while stalled ----------------
    // Recapturing every stalled cycle keeps a bypassed live write persistent.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold1_p2 <= '0;
            hold2_p2 <= '0;
        end else if (ex_valid && !ex_ready) begin
            hold1_p2 <= opnd1;
            hold2_p2 <= opnd2;
        end
    end

    assign ex_pc      = pc_p1;
    assign ex_imm     = imm_p1;
    assign ex_rd      = rd_p1;
    assign ex_op      = op_p1;
    assign ex_wreg    = wreg_p1;
    assign ex_illegal = ill_p1;
    assign ex_rs1_val = opnd1;
    assign ex_rs2_val = opnd2;

    logic fire_unused;
    assign fire_unused = fire;

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage
// Directed bench for id_stage with a small synchronous regfile model.
// ----------------------------------------------------------------------------
module tb_id_stage;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    logic               clk = 1'b0;
    logic               rstn;
    logic               if_valid;
    logic               if_ready;
    logic [31:0]        if_instr;
    logic [XLEN-1:0]    if_pc;
    logic [RADDR_W-1:0] rf_radd1;
    logic [RADDR_W-1:0] rf_radd2;
    logic [XLEN-1:0]    rf_rdata1;
    logic [XLEN-1:0]    rf_rdata2;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_wadd;
    logic [XLEN-1:0]    wb_wdata;
    logic               ex_valid;
    logic               ex_ready;
    logic [XLEN-1:0]    ex_pc;
    logic [XLEN-1:0]    ex_rs1_val;
    logic [XLEN-1:0]    ex_rs2_val;
    logic [XLEN-1:0]    ex_imm;
    logic [RADDR_W-1:0] ex_rd;
    logic [3:0]         ex_op;
    logic               ex_wreg;
    logic               ex_illegal;

    logic [XLEN-1:0] regs [32];
    logic [31:0]     exp_byp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // synchronous-read regfile: data valid one cycle after the address edge
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_radd1];
        rf_rdata2 <= regs[rf_radd2];
    end

    id_stage #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .rf_radd1   (rf_radd1),
        .rf_radd2   (rf_radd2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .wb_we      (wb_we),
        .wb_wadd    (wb_wadd),
        .wb_wdata   (wb_wdata),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_pc      (ex_pc),
        .ex_rs1_val (ex_rs1_val),
        .ex_rs2_val (ex_rs2_val),
        .ex_imm     (ex_imm),
        .ex_rd      (ex_rd),
        .ex_op      (ex_op),
        .ex_wreg    (ex_wreg),
        .ex_illegal (ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1]  = 32'd1;
        regs[2]  = 32'd2;
        regs[31] = 32'h31;
        rstn = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        wb_we = 1'b0; wb_wadd = '0; wb_wdata = '0; ex_ready = 1'b0;
`ifdef ID_BYPASS_EN
        exp_byp = 32'hDEAD;
`else
        exp_byp = 32'd1;
`endif

        // reset state
        @(negedge clk); #1;
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_rs1", ex_rs1_val, 32'd0);
        chk("rst_wreg", 32'(ex_wreg), 32'd0);
        chk("rst_illegal", 32'(ex_illegal), 32'd0);
        rstn = 1'b1;

        // add x3,x1,x2
        @(negedge clk); if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h100; ex_ready = 1'b1; #1;
        chk("add_radd1", 32'(rf_radd1), 32'd1);
        chk("add_radd2", 32'(rf_radd2), 32'd2);
        chk("add_if_ready", 32'(if_ready), 32'd1);
        @(negedge clk); if_valid = 1'b0; #1;
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rs1", ex_rs1_val, 32'd1);
        chk("add_rs2", ex_rs2_val, 32'd2);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_wreg", 32'(ex_wreg), 32'd1);
        chk("add_pc", ex_pc, 32'h100);
        chk("add_op", 32'(ex_op), 32'd0);
        chk("add_illegal", 32'(ex_illegal), 32'd0);
        @(negedge clk); #1;
        chk("add_done_valid", 32'(ex_valid), 32'd0);
        chk("add_done_ready", 32'(if_ready), 32'd1);

        // addi x0,x0,0 with a nonzero x0 in the regfile
        regs[0] = 32'h55; if_valid = 1'b1; if_instr = 32'h00000013; if_pc = 32'h104;
        @(negedge clk); if_valid = 1'b0; #1;
        chk("nop_valid", 32'(ex_valid), 32'd1);
        chk("nop_rs1", ex_rs1_val, 32'd0);
        chk("nop_rs2", ex_rs2_val, 32'd0);
        chk("nop_wreg", 32'(ex_wreg), 32'd0);
        @(negedge clk); #1;

        // addi x5,x1,-1 stalled three cycles
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'hFFF08293; if_pc = 32'h200;
        @(negedge clk); #1;
        chk("rd_valid", 32'(ex_valid), 32'd1);
        chk("rd_if_ready", 32'(if_ready), 32'd0);
        chk("rd_rs1", ex_rs1_val, 32'd1);
        chk("rd_rs2", ex_rs2_val, 32'h31);
        chk("rd_imm", ex_imm, 32'hFFFFFFFF);
        chk("rd_rd", 32'(ex_rd), 32'd5);
        chk("rd_wreg", 32'(ex_wreg), 32'd1);
        if_instr = 32'h00210233; if_pc = 32'h204;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("hold_valid", 32'(ex_valid), 32'd1);
            chk("hold_if_ready", 32'(if_ready), 32'd0);
            chk("hold_rs1", ex_rs1_val, 32'd1);
            chk("hold_rs2", ex_rs2_val, 32'h31);
            chk("hold_pc", ex_pc, 32'h200);
            chk("hold_imm", ex_imm, 32'hFFFFFFFF);
            chk("hold_rd", 32'(ex_rd), 32'd5);
        end
        ex_ready = 1'b1; #1;
        chk("hold_release_ready", 32'(if_ready), 32'd1);
        chk("hold_release_rs1", ex_rs1_val, 32'd1);

        // back-to-back stream, fire and accept on the same edge
        @(negedge clk); #1;
        chk("b2b0_pc", ex_pc, 32'h204);
        chk("b2b0_rs1", ex_rs1_val, 32'd2);
        chk("b2b0_rs2", ex_rs2_val, 32'd2);
        chk("b2b0_rd", 32'(ex_rd), 32'd4);
        if_instr = 32'h002081B3; if_pc = 32'h208;
        @(negedge clk); #1;
        chk("b2b1_pc", ex_pc, 32'h208);
        chk("b2b1_rs1", ex_rs1_val, 32'd1);
        chk("b2b1_rd", 32'(ex_rd), 32'd3);
        if_instr = 32'h123453B7; if_pc = 32'h20C;
        @(negedge clk); #1;
        chk("lui_pc", ex_pc, 32'h20C);
        chk("lui_imm", ex_imm, 32'h12345000);
        chk("lui_op", 32'(ex_op), 32'd10);
        chk("lui_wreg", 32'(ex_wreg), 32'd1);
        chk("lui_rd", 32'(ex_rd), 32'd7);
        if_instr = 32'hFE20AE23; if_pc = 32'h210;
        @(negedge clk); #1;
        chk("sw_pc", ex_pc, 32'h210);
        chk("sw_imm", ex_imm, 32'hFFFFFFFC);
        chk("sw_wreg", 32'(ex_wreg), 32'd0);
        chk("sw_rs2", ex_rs2_val, 32'd2);
        chk("sw_op", 32'(ex_op), 32'd0);
        if_instr = 32'hFE208CE3; if_pc = 32'h214;
        @(negedge clk); #1;
        chk("beq_imm", ex_imm, 32'hFFFFFFF8);
        chk("beq_op", 32'(ex_op), 32'd1);
        chk("beq_wreg", 32'(ex_wreg), 32'd0);
        chk("beq_illegal", 32'(ex_illegal), 32'd0);
        if_instr = 32'h000000EF; if_pc = 32'h218;
        @(negedge clk); if_valid = 1'b0; #1;
        chk("jal_valid", 32'(ex_valid), 32'd1);
        chk("jal_illegal", 32'(ex_illegal), 32'd1);
        chk("jal_wreg", 32'(ex_wreg), 32'd0);
        chk("jal_pc", ex_pc, 32'h218);
        @(negedge clk); #1;
        chk("stream_done_valid", 32'(ex_valid), 32'd0);

        // writeback on the accept edge
        if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h300;
        wb_we = 1'b1; wb_wadd = 5'd1; wb_wdata = 32'hDEAD;
        @(negedge clk); wb_we = 1'b0; if_valid = 1'b0; #1;
        chk("byp_rs1", ex_rs1_val, exp_byp);
        chk("byp_rs2", ex_rs2_val, 32'd2);
        @(negedge clk); #1;

        // reset while in HOLD
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h400;
        @(negedge clk); if_valid = 1'b0; #1;
        @(negedge clk); #1;
        chk("rh_valid", 32'(ex_valid), 32'd1);
        chk("rh_pc", ex_pc, 32'h400);
        rstn = 1'b0; #1;
        chk("rh_rst_valid", 32'(ex_valid), 32'd0);
        chk("rh_rst_if_ready", 32'(if_ready), 32'd1);
        chk("rh_rst_pc", ex_pc, 32'd0);
        chk("rh_rst_rs1", ex_rs1_val, 32'd0);
        chk("rh_rst_wreg", 32'(ex_wreg), 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); #1;
        chk("rh_after_if_ready", 32'(if_ready), 32'd1);
        chk("rh_after_valid", 32'(ex_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
